alu_pipe_param: RTL
===================

// Module: alu_pipe_param
// PURPOSE
//  Parametrised 2-stage pipelined integer ALU; next generation of the 8-bit add/sub/and/xor pipe.
//  Adds generic width, 8 operations, a NZCV flag output and full valid/ready backpressure.
//  Sits between an operand source (sequencer/regfile) and a result consumer.
//  Lossless and in-order under stalls.
// PARAMETERS
//  WIDTH   8   operand/result width in bits, >=2
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      operand beat valid
//  in_ready   out  1      block accepts beat this cycle
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  op         in   3      opcode (see BEHAVIOUR)
//  out_valid  out  1      result beat valid
//  out_ready  in   1      consumer accepts result this cycle
//  result     out  WIDTH  ALU result
//  flags      out  4      {N,Z,C,V}
// BEHAVIOUR
//  Reset (async, rst=1): every register clears immediately: s1_valid=0, out_valid=0, result=0,
//   flags=0. in_ready=1 once reset is low. A reset mid-operation discards all in-flight beats.
//  Opcodes: 000 ADD a+b; 001 SUB a-b (a + ~b + 1); 010 AND; 011 OR; 100 XOR;
//   101 SHL a<<1; 110 SHR a>>1 logical; 111 PASS a. No illegal opcode exists.
//  Flags: N=result[WIDTH-1]; Z=(result==0) for every op.
//   C: ADD = carry out; SUB = NOT borrow (1 when a>=b unsigned); SHL = a[WIDTH-1];
//   SHR = a[0]; all other ops 0.
//   V: ADD = (a,b same sign) && result sign differs; SUB = (a,b different sign) &&
//   result sign != a sign; all other ops 0.
//  Arithmetic is modulo 2^WIDTH; carry is bit WIDTH of the WIDTH+1-bit sum.
//  Stage 1: input register {a,b,op} plus s1_valid. Stage 2: compute and register
//   result/flags/out_valid.
//  Enables: s2_en = !out_valid | out_ready; s1_en = !s1_valid | s2_en; in_ready = s1_en.
//  Input transfer when in_valid & in_ready. Output transfer when out_valid & out_ready.
//  s1 load: when s1_en, s1_valid <= in_valid; operands load only when in_valid.
//  s2 load: when s2_en, out_valid <= s1_valid; result/flags load only when s1_valid.
//  Latency: 2 cycles from input transfer to out_valid with out_ready held high.
//   Throughput is 1 beat/cycle.
//  Stall: with out_ready=0, up to 2 beats are held (s1 + s2), then in_ready=0.
//   in_ready is combinational from out_ready (no skid buffer).
//  Simultaneous input and output transfer in a full pipe: both beats advance in the same
//   cycle; no bubble, no loss.
//  result/flags hold their value while out_valid=0 or while stalled.
//   Never change while out_valid & !out_ready.
// STRUCTURE
//  Shared package/header alu_pkg: opcode localparams OP_ADD..OP_PASS (3 bits) and
//   flag bit indices FLG_N=3, FLG_Z=2, FLG_C=1, FLG_V=0.
//  One sub-module, alu_addsub #(WIDTH): inputs a, b, sub; outputs sum[WIDTH-1:0], cout, ovf.
//   Implemented as a generate ripple of full adders with an XOR on b and cin=sub.
//  Logic ops, shifts, mux and flags live inline in alu_pipe_param.
// TESTING
//  1. WIDTH=8, ADD a=FF b=01 -> 2 cycles later result=00, flags N0 Z1 C1 V0.
//  2. SUB a=05 b=07 -> result=FE, N1 Z0 C0 V0. SUB a=80 b=01 -> result=7F, V1 C1.
//  3. ADD 7F+01 -> result=80, N1 V1 C0. SHL a=81 -> 02, C1. SHR a=03 -> 01, C1.
//  4. Backpressure: out_ready=0 while 4 beats are offered.
//     -> exactly 2 are accepted and in_ready=0 afterwards.
//     -> raising out_ready delivers all 4 in order, once each, with result held stable when stalled.
//  5. Streaming: in_valid=out_ready=1 for 16 random beats -> one result per cycle after
//     2-cycle latency, matching the reference model.
//  6. Assert rst with 2 beats in flight -> out_valid=0, result=0 immediately, nothing emitted.
//     Then rerun test 1 with WIDTH=16: FFFF+0001 -> 0000, C1 Z1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode encodings and flag bit positions for the pipelined ALU family.
// Shared by every file of the slice; contains no logic of its own.
package alu_pkg;
   localparam logic [2:0] OP_ADD  = 3'd0;
   localparam logic [2:0] OP_SUB  = 3'd1;
   localparam logic [2:0] OP_AND  = 3'd2;
   localparam logic [2:0] OP_OR   = 3'd3;
   localparam logic [2:0] OP_XOR  = 3'd4;
   localparam logic [2:0] OP_SHL  = 3'd5;
   localparam logic [2:0] OP_SHR  = 3'd6;
   localparam logic [2:0] OP_PASS = 3'd7;

   localparam int FLG_N = 3;
   localparam int FLG_Z = 2;
   localparam int FLG_C = 1;
   localparam int FLG_V = 0;
endpackage

// File: rtl/alu_addsub.sv
// Ripple-carry adder/subtractor: sub=1 computes a + ~b + 1; combinational, no backpressure.
// ovf is signed overflow, taken as carry-into-MSB xor carry-out.
module alu_addsub #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);
   logic [WIDTH:0]   c;
   logic [WIDTH-1:0] bx;

   assign c[0] = sub;
   assign bx   = b ^ {WIDTH{sub}};

   genvar i;
   generate
      for (i = 0; i < WIDTH; i++) begin : g_fa
         assign sum[i]   = a[i] ^ bx[i] ^ c[i];
         assign c[i+1]   = (a[i] & bx[i]) | (c[i] & (a[i] ^ bx[i]));
      end
   endgenerate

   assign cout = c[WIDTH];
   assign ovf  = c[WIDTH] ^ c[WIDTH-1];
endmodule

// File: rtl/alu_pipe_param.sv
// 2-stage pipelined ALU with NZCV flags; 2-cycle latency, 1 beat/cycle throughput.
// Valid/ready backpressure holds up to 2 beats; in_ready is combinational from out_ready.
module alu_pipe_param #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [3:0]       flags
);
   import alu_pkg::*;

   logic             s1_valid;
   logic [WIDTH-1:0] s1_a, s1_b;
   logic [2:0]       s1_op;
   logic             s1_en, s2_en;

   logic [WIDTH-1:0] as_sum;
   logic             as_cout, as_ovf;
   logic [WIDTH-1:0] res_nxt;
   logic             c_nxt, v_nxt;
   logic [3:0]       flags_nxt;

   assign s2_en    = !out_valid || out_ready;
   assign s1_en    = !s1_valid || s2_en;
   assign in_ready = s1_en;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_a     <= '0;
         s1_b     <= '0;
         s1_op    <= OP_ADD;
      end else if (s1_en) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_a  <= a;
            s1_b  <= b;
            s1_op <= op;
         end
      end
   end

   alu_addsub #(.WIDTH(WIDTH)) u_addsub (
      .a    (s1_a),
      .b    (s1_b),
      .sub  (s1_op == OP_SUB),
      .sum  (as_sum),
      .cout (as_cout),
      .ovf  (as_ovf)
   );

   always_comb begin
      res_nxt = s1_a;
      c_nxt   = 1'b0;
      v_nxt   = 1'b0;
      case (s1_op)
         OP_ADD, OP_SUB: begin
            res_nxt = as_sum;
            c_nxt   = as_cout;
            v_nxt   = as_ovf;
         end
         OP_AND: res_nxt = s1_a & s1_b;
         OP_OR:  res_nxt = s1_a | s1_b;
         OP_XOR: res_nxt = s1_a ^ s1_b;
         OP_SHL: begin
            res_nxt = {s1_a[WIDTH-2:0], 1'b0};
            c_nxt   = s1_a[WIDTH-1];
         end
         OP_SHR: begin
            res_nxt = {1'b0, s1_a[WIDTH-1:1]};
            c_nxt   = s1_a[0];
         end
         default: res_nxt = s1_a;
      endcase
   end

   always_comb begin
      flags_nxt        = '0;
      flags_nxt[FLG_N] = res_nxt[WIDTH-1];
      flags_nxt[FLG_Z] = (res_nxt == '0);
      flags_nxt[FLG_C] = c_nxt;
      flags_nxt[FLG_V] = v_nxt;
   end

   // result/flags only move on a real beat, so they hold through bubbles and stalls
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         result    <= '0;
         flags     <= '0;
      end else if (s2_en) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            result <= res_nxt;
            flags  <= flags_nxt;
         end
      end
   end
endmodule
